// File: rtl/nadajnik_uart_if.sv
// Handshake and line bundle for the nadajnik_uart serial transmitter.
// The master drives words in; the slave (the transmitter) drives status and the line.
interface nadajnik_uart_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 TXD_o;

    modport master (output data_i, valid_i, input ready_o, busy_o, done_o, TXD_o);
    modport slave  (input data_i, valid_i, output ready_o, busy_o, done_o, TXD_o);
endinterface

// File: rtl/nadajnik_uart.sv
// RS-232 framing transmitter: start, DATA_BITS data LSB first, optional parity, stop bit(s).
// Define NADAJNIK_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1).
module nadajnik_uart #(
    parameter int DIV        = 10,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    nadajnik_uart_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef NADAJNIK_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] DIV_M2  = 16'(DIV - 2);
    localparam logic [3:0]  DATA_M1 = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_M1 = 4'(STOP_BITS - 1);

    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("nadajnik_uart: DIV out of range");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("nadajnik_uart: DATA_BITS out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("nadajnik_uart: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("nadajnik_uart: PARITY_ODD must be 0 or 1");
    end

    logic [2:0]           state;
    logic [15:0]          cyc;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 txd, ready, busy, done;
`ifdef NADAJNIK_PARITY_EN
    logic                 par_bit;
`endif

    assign bus.TXD_o   = txd;
    assign bus.ready_o = ready;
    assign bus.busy_o  = busy;
    assign bus.done_o  = done;

    logic bit_end, last_stop, accept;
    assign bit_end   = (cyc == DIV_M1);
    assign last_stop = (bit_cnt == STOP_M1);
    // ready is only high in IDLE or the final stop-bit cycle, so accept covers both entry paths
    assign accept    = bus.valid_i & ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            cyc     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef NADAJNIK_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (state == S_STOP) done <= 1'b1;
                shreg   <= bus.data_i;
                txd     <= 1'b0;
                busy    <= 1'b1;
                ready   <= 1'b0;
                cyc     <= '0;
                bit_cnt <= '0;
                state   <= S_START;
`ifdef NADAJNIK_PARITY_EN
                par_bit <= (^bus.data_i) ^ 1'(PARITY_ODD);
`endif
            end else begin
                case (state)
                    S_IDLE: ;
                    S_START: begin
                        if (bit_end) begin
                            cyc     <= '0;
                            bit_cnt <= '0;
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            state   <= S_DATA;
                        end else cyc <= cyc + 16'd1;
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            cyc <= '0;
                            if (bit_cnt == DATA_M1) begin
                                bit_cnt <= '0;
`ifdef NADAJNIK_PARITY_EN
                                txd   <= par_bit;
                                state <= S_PAR;
`else
                                txd   <= 1'b1;
                                state <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                txd     <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end else cyc <= cyc + 16'd1;
                    end
`ifdef NADAJNIK_PARITY_EN
                    S_PAR: begin
                        if (bit_end) begin
                            cyc   <= '0;
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else cyc <= cyc + 16'd1;
                    end
`endif
                    S_STOP: begin
                        if (bit_end) begin
                            cyc <= '0;
                            if (last_stop) begin
                                // no follow-on word: frame ends, line stays high
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            cyc <= cyc + 16'd1;
                            if (last_stop && cyc == DIV_M2) ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        txd   <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
